// File: rtl/controller_pkg.sv
// Shared encodings for the instruction-sequencing controller: states, opcodes,
// ALU and write-source codes, and the control-strobe bundle.
package controller_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC_M  = 4'd3,
        S_EXEC_L  = 4'd4,
        S_EXEC_A1 = 4'd5,
        S_EXEC_A2 = 4'd6,
        S_EXEC_A3 = 4'd7,
        S_EXEC_J  = 4'd8,
        S_HALT    = 4'd9,
        S_ERROR   = 4'd15
    } state_t;

    localparam logic [2:0] OP_MOVE = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_JNZ  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_XOR = 2'd1;
    localparam logic [1:0] ALU_SUB = 2'd2;

    localparam logic [1:0] WSEL_RY  = 2'd0;
    localparam logic [1:0] WSEL_MEM = 2'd1;
    localparam logic [1:0] WSEL_G   = 2'd2;

    // Width of the ALU settle counter; holds ALU_CYCLES-1 for 1..15 cycles.
    localparam int CW = 4;

    typedef struct packed {
        logic       fetch_req;
        logic       rf_wr;
        logic [1:0] rf_wsel;
        logic       a_load;
        logic       g_load;
        logic [1:0] alu_op;
        logic       pc_inc;
        logic       pc_load;
        logic       halted;
        logic       error;
    } ctrl_t;

endpackage

// File: rtl/controller_decode.sv
// Combinational next-state and strobe decode for the controller; holds no state.
module controller_decode
    import controller_pkg::*;
#(
    parameter int OPW = 3
) (
    input  state_t           i_state,
    input  logic [OPW-1:0]   i_opcode,
    input  logic             i_run,
    input  logic             i_fetch_valid,
    input  logic             i_rx_zero,
    input  logic [CW-1:0]    i_cnt,
    output state_t           o_next_state,
    output ctrl_t            o_ctrl,
    output logic             o_ir_load,
    output logic             o_cnt_load,
    output logic             o_cnt_dec
);

    state_t w_done_state;

    // Every instruction ends the same way: keep going if Run, else park in IDLE.
    assign w_done_state = i_run ? S_FETCH : S_IDLE;

    always_comb begin
        o_next_state = i_state;
        o_ir_load    = 1'b0;
        o_cnt_load   = 1'b0;
        o_cnt_dec    = 1'b0;
        case (i_state)
            S_IDLE: begin
                if (i_run) o_next_state = S_FETCH;
            end
            S_FETCH: begin
                if (i_fetch_valid) begin
                    o_ir_load    = 1'b1;
                    o_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                case (i_opcode)
                    OPW'(OP_MOVE): o_next_state = S_EXEC_M;
                    OPW'(OP_LOAD): o_next_state = S_EXEC_L;
                    OPW'(OP_ADD),
                    OPW'(OP_XOR),
                    OPW'(OP_SUB): begin
                        o_next_state = S_EXEC_A1;
                        o_cnt_load   = 1'b1;
                    end
                    OPW'(OP_JNZ):  o_next_state = S_EXEC_J;
                    OPW'(OP_HALT): o_next_state = S_HALT;
                    default:       o_next_state = S_ERROR;
                endcase
            end
            S_EXEC_M:  o_next_state = w_done_state;
            S_EXEC_L: begin
                if (i_fetch_valid) o_next_state = w_done_state;
            end
            S_EXEC_A1: o_next_state = S_EXEC_A2;
            S_EXEC_A2: begin
                if (i_cnt != '0) o_cnt_dec = 1'b1;
                else             o_next_state = S_EXEC_A3;
            end
            S_EXEC_A3: o_next_state = w_done_state;
            S_EXEC_J:  o_next_state = w_done_state;
            S_HALT: begin
                if (!i_run) o_next_state = S_IDLE;
            end
            S_ERROR:   o_next_state = S_ERROR;
            default:   o_next_state = S_ERROR;
        endcase
    end

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.fetch_req = 1'b1;
                o_ctrl.pc_inc    = i_fetch_valid;
            end
            S_EXEC_L: begin
                o_ctrl.fetch_req = 1'b1;
                if (i_fetch_valid) begin
                    o_ctrl.rf_wr   = 1'b1;
                    o_ctrl.rf_wsel = WSEL_MEM;
                    o_ctrl.pc_inc  = 1'b1;
                end
            end
            S_EXEC_M: begin
                o_ctrl.rf_wr   = 1'b1;
                o_ctrl.rf_wsel = WSEL_RY;
            end
            S_EXEC_A1: o_ctrl.a_load = 1'b1;
            S_EXEC_A2: begin
                o_ctrl.g_load = 1'b1;
                case (i_opcode)
                    OPW'(OP_XOR): o_ctrl.alu_op = ALU_XOR;
                    OPW'(OP_SUB): o_ctrl.alu_op = ALU_SUB;
                    default:      o_ctrl.alu_op = ALU_ADD;
                endcase
            end
            S_EXEC_A3: begin
                o_ctrl.rf_wr   = 1'b1;
                o_ctrl.rf_wsel = WSEL_G;
            end
            S_EXEC_J:  o_ctrl.pc_load = ~i_rx_zero;
            S_HALT:    o_ctrl.halted  = 1'b1;
            S_ERROR:   o_ctrl.error   = 1'b1;
            default:   o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/controller_fsm.sv
// Instruction-sequencing controller: owns the state, instruction and ALU settle
// counter registers and drives the datapath strobes from the decode block.
module controller_fsm
    import controller_pkg::*;
#(
    parameter  int OPW        = 3,
    parameter  int RW         = 3,
    parameter  int ALU_CYCLES = 1,
    localparam int IW         = OPW + 2 * RW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_run,
    output logic          o_fetch_req,
    input  logic          i_fetch_valid,
    input  logic [IW-1:0] i_mem_data,
    input  logic          i_rx_zero,
    output logic          o_rf_wr,
    output logic [1:0]    o_rf_wsel,
    output logic [RW-1:0] o_rx_sel,
    output logic [RW-1:0] o_ry_sel,
    output logic          o_a_load,
    output logic          o_g_load,
    output logic [1:0]    o_alu_op,
    output logic          o_pc_inc,
    output logic          o_pc_load,
    output logic          o_halted,
    output logic          o_error,
    output logic [3:0]    o_state
);

    state_t        r_state;
    logic [IW-1:0] r_ir;
    logic [CW-1:0] r_cnt;

    state_t        w_next_state;
    ctrl_t         w_ctrl;
    logic          w_ir_load;
    logic          w_cnt_load;
    logic          w_cnt_dec;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_ir_load) r_ir <= i_mem_data;
            // Loaded with ALU_CYCLES-1 so EXEC_A2 lasts exactly ALU_CYCLES cycles.
            if (w_cnt_load)     r_cnt <= CW'(ALU_CYCLES - 1);
            else if (w_cnt_dec) r_cnt <= r_cnt - 1'b1;
        end
    end

    controller_decode #(
        .OPW (OPW)
    ) u_decode (
        .i_state       (r_state),
        .i_opcode      (r_ir[IW-1:IW-OPW]),
        .i_run         (i_run),
        .i_fetch_valid (i_fetch_valid),
        .i_rx_zero     (i_rx_zero),
        .i_cnt         (r_cnt),
        .o_next_state  (w_next_state),
        .o_ctrl        (w_ctrl),
        .o_ir_load     (w_ir_load),
        .o_cnt_load    (w_cnt_load),
        .o_cnt_dec     (w_cnt_dec)
    );

    assign o_fetch_req = w_ctrl.fetch_req;
    assign o_rf_wr     = w_ctrl.rf_wr;
    assign o_rf_wsel   = w_ctrl.rf_wsel;
    assign o_a_load    = w_ctrl.a_load;
    assign o_g_load    = w_ctrl.g_load;
    assign o_alu_op    = w_ctrl.alu_op;
    assign o_pc_inc    = w_ctrl.pc_inc;
    assign o_pc_load   = w_ctrl.pc_load;
    assign o_halted    = w_ctrl.halted;
    assign o_error     = w_ctrl.error;
    assign o_rx_sel    = r_ir[2*RW-1:RW];
    assign o_ry_sel    = r_ir[RW-1:0];
    assign o_state     = r_state;

endmodule

// File: tb/tb_controller_fsm.sv
// Bench for controller_fsm: two instances (ALU_CYCLES 1 and 4) driven by
// per-instruction transaction tasks that queue the expected per-cycle outputs.
module tb_controller_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_s, run_s, fv_s, rxz_s;
  logic [8:0] md_s [2];
  logic [1:0] fr_s, wr_s, al_s, gl_s, pi_s, pl_s, hl_s, er_s;
  logic [1:0] ws_s [2];
  logic [1:0] ao_s [2];
  logic [2:0] rx_s [2];
  logic [2:0] ry_s [2];
  logic [3:0] st_s [2];

  controller_fsm #(.OPW(3), .RW(3), .ALU_CYCLES(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst_s[0]), .i_run(run_s[0]), .o_fetch_req(fr_s[0]),
    .i_fetch_valid(fv_s[0]), .i_mem_data(md_s[0]), .i_rx_zero(rxz_s[0]),
    .o_rf_wr(wr_s[0]), .o_rf_wsel(ws_s[0]), .o_rx_sel(rx_s[0]), .o_ry_sel(ry_s[0]),
    .o_a_load(al_s[0]), .o_g_load(gl_s[0]), .o_alu_op(ao_s[0]), .o_pc_inc(pi_s[0]),
    .o_pc_load(pl_s[0]), .o_halted(hl_s[0]), .o_error(er_s[0]), .o_state(st_s[0])
  );

  controller_fsm #(.OPW(3), .RW(3), .ALU_CYCLES(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst_s[1]), .i_run(run_s[1]), .o_fetch_req(fr_s[1]),
    .i_fetch_valid(fv_s[1]), .i_mem_data(md_s[1]), .i_rx_zero(rxz_s[1]),
    .o_rf_wr(wr_s[1]), .o_rf_wsel(ws_s[1]), .o_rx_sel(rx_s[1]), .o_ry_sel(ry_s[1]),
    .o_a_load(al_s[1]), .o_g_load(gl_s[1]), .o_alu_op(ao_s[1]), .o_pc_inc(pi_s[1]),
    .o_pc_load(pl_s[1]), .o_halted(hl_s[1]), .o_error(er_s[1]), .o_state(st_s[1])
  );

  // Flag layout: fetch_req wr wsel[1:0] a_load g_load alu_op[1:0] pc_inc pc_load halted error
  localparam logic [11:0] F_FR   = 12'h800;
  localparam logic [11:0] F_WR   = 12'h400;
  localparam logic [11:0] WS_MEM = 12'h100;
  localparam logic [11:0] WS_G   = 12'h200;
  localparam logic [11:0] F_AL   = 12'h080;
  localparam logic [11:0] F_GL   = 12'h040;
  localparam logic [11:0] F_PI   = 12'h008;
  localparam logic [11:0] F_PL   = 12'h004;
  localparam logic [11:0] F_HL   = 12'h002;
  localparam logic [11:0] F_ER   = 12'h001;

  int checks = 0;
  int errors = 0;
  logic [21:0] exp_q[$];
  logic [21:0] exp_q4[$];
  logic [8:0] m_ir [2];
  int cnt_pi [2], cnt_pl [2], cnt_gl [2], cnt_sub [2], cnt_wr [2], cnt_fr [2], cnt_hl [2], cnt_er [2];
  int st_log[$];
  logic log_en = 1'b0;

  function automatic logic [21:0] act(input int k);
    return {fr_s[k], wr_s[k], ws_s[k], al_s[k], gl_s[k], ao_s[k], pi_s[k], pl_s[k],
            hl_s[k], er_s[k], st_s[k], rx_s[k], ry_s[k]};
  endfunction

  function automatic logic [21:0] ev(input int st, input logic [11:0] fl, input logic [8:0] ir);
    return {fl, 4'(st), ir[5:3], ir[2:0]};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [8:0] rnd9();
    return 9'($urandom);
  endfunction

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, a, e, $time);
    end
  endtask

  // Compare process: one expected vector per driven cycle, per instance.
  always @(negedge clk) begin
    logic [21:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act(0);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_alu1 act=%h exp=%h t=%0t", a, e, $time);
      end
    end
    if (exp_q4.size() > 0) begin
      e = exp_q4.pop_front();
      a = act(1);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_alu4 act=%h exp=%h t=%0t", a, e, $time);
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (pi_s[k]) cnt_pi[k]++;
      if (pl_s[k]) cnt_pl[k]++;
      if (gl_s[k]) cnt_gl[k]++;
      if (gl_s[k] && ao_s[k] == 2'd2) cnt_sub[k]++;
      if (wr_s[k]) cnt_wr[k]++;
      if (fr_s[k]) cnt_fr[k]++;
      if (hl_s[k]) cnt_hl[k]++;
      if (er_s[k]) cnt_er[k]++;
    end
    if (log_en) st_log.push_back(int'(st_s[0]));
  end

  task automatic clr();
    for (int k = 0; k < 2; k++) begin
      cnt_pi[k] = 0; cnt_pl[k] = 0; cnt_gl[k] = 0; cnt_sub[k] = 0;
      cnt_wr[k] = 0; cnt_fr[k] = 0; cnt_hl[k] = 0; cnt_er[k] = 0;
    end
    st_log.delete();
  endtask

  // One clock cycle: drive instance k, queue its expected outputs for this cycle.
  task automatic cyc(input int k, input logic rst, input logic run, input logic fv,
                     input logic [8:0] md, input logic rxz, input logic en, input logic [21:0] e);
    rst_s = '0; run_s = '0; fv_s = '0; rxz_s = '0;
    rst_s[k] = rst; run_s[k] = run; fv_s[k] = fv; rxz_s[k] = rxz; md_s[k] = md;
    if (en) begin
      if (k == 0) exp_q.push_back(e);
      else        exp_q4.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int k);
    cyc(k, 1'b1, rb(), rb(), rnd9(), rb(), 1'b0, '0);
    m_ir[k] = '0;
    cyc(k, 1'b0, 1'b0, 1'b1, rnd9(), rb(), 1'b1, ev(0, 12'h000, 9'h000));
    cyc(k, 1'b0, 1'b0, 1'b0, rnd9(), rb(), 1'b1, ev(0, 12'h000, 9'h000));
  endtask

  task automatic start_run(input int k);
    cyc(k, 1'b0, 1'b1, 1'b0, rnd9(), rb(), 1'b1, ev(0, 12'h000, m_ir[k]));
  endtask

  // From FETCH: d1 wait cycles, the valid beat, then the DECODE cycle.
  task automatic fetch_decode(input int k, input logic [8:0] ins, input int d1);
    for (int i = 0; i < d1; i++)
      cyc(k, 1'b0, rb(), 1'b0, rnd9(), rb(), 1'b1, ev(1, F_FR, m_ir[k]));
    cyc(k, 1'b0, rb(), 1'b1, ins, rb(), 1'b1, ev(1, F_FR | F_PI, m_ir[k]));
    m_ir[k] = ins;
    cyc(k, 1'b0, rb(), 1'b0, rnd9(), rb(), 1'b1, ev(2, 12'h000, ins));
  endtask

  // A whole non-halting instruction starting in FETCH and ending back in FETCH.
  task automatic run_instr(input int k, input logic [8:0] ins, input int d1, input int d2,
                           input logic rxz, input logic run_end);
    int n_alu;
    logic [11:0] ao_f;
    n_alu = (k == 0) ? 1 : 4;
    ao_f = 12'(int'(ins[8:6]) - 2) << 4;
    fetch_decode(k, ins, d1);
    case (ins[8:6])
      3'd0: cyc(k, 1'b0, run_end, 1'b0, rnd9(), rb(), 1'b1, ev(3, F_WR, ins));
      3'd1: begin
        for (int i = 0; i < d2; i++)
          cyc(k, 1'b0, rb(), 1'b0, rnd9(), rb(), 1'b1, ev(4, F_FR, ins));
        cyc(k, 1'b0, run_end, 1'b1, rnd9(), rb(), 1'b1, ev(4, F_FR | F_WR | WS_MEM | F_PI, ins));
      end
      3'd2, 3'd3, 3'd4: begin
        cyc(k, 1'b0, rb(), 1'b0, rnd9(), rb(), 1'b1, ev(5, F_AL, ins));
        for (int i = 0; i < n_alu; i++)
          cyc(k, 1'b0, rb(), 1'b0, rnd9(), rb(), 1'b1, ev(6, F_GL | ao_f, ins));
        cyc(k, 1'b0, run_end, 1'b0, rnd9(), rb(), 1'b1, ev(7, F_WR | WS_G, ins));
      end
      default: cyc(k, 1'b0, run_end, 1'b0, rnd9(), rxz, 1'b1, ev(8, rxz ? 12'h000 : F_PL, ins));
    endcase
    if (!run_end) start_run(k);
  endtask

  task automatic run_random(input int k, input int n);
    logic [2:0] op;
    for (int i = 0; i < n; i++) begin
      op = 3'($urandom_range(0, 5));
      run_instr(k, {op, 6'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3), rb(), rb());
    end
  endtask

  initial begin
    rst_s = '1; run_s = '0; fv_s = '0; rxz_s = '0;
    md_s[0] = '0; md_s[1] = '0; m_ir[0] = '0; m_ir[1] = '0;
    clr();
    repeat (2) @(posedge clk);
    #1;

    // ALU_CYCLES=1 instance
    do_reset(0);
    chk("reset_state", int'(st_s[0]), 0);
    chk("reset_outs", int'(act(0)), 0);
    start_run(0);

    clr(); log_en = 1'b1;
    run_instr(0, 9'h08A, 0, 0, 1'b0, 1'b1);
    log_en = 1'b0;
    chk("add_len", st_log.size(), 5);
    if (st_log.size() == 5) begin
      chk("add_s0", st_log[0], 1); chk("add_s1", st_log[1], 2); chk("add_s2", st_log[2], 5);
      chk("add_s3", st_log[3], 6); chk("add_s4", st_log[4], 7);
    end
    chk("add_rx", int'(rx_s[0]), 1);
    chk("add_ry", int'(ry_s[0]), 2);
    chk("add_next", int'(st_s[0]), 1);
    chk("add_gl", cnt_gl[0], 1);

    clr();
    run_instr(0, 9'h058, 3, 3, 1'b0, 1'b1);
    chk("load_pc_inc", cnt_pi[0], 2);
    chk("load_fetch_req", cnt_fr[0], 8);
    chk("load_wr", cnt_wr[0], 1);

    clr();
    run_instr(0, 9'h165, 0, 0, 1'b0, 1'b1);
    chk("jnz_taken", cnt_pl[0], 1);
    chk("jnz_taken_next", int'(st_s[0]), 1);
    clr();
    run_instr(0, 9'h165, 0, 0, 1'b1, 1'b1);
    chk("jnz_not_taken", cnt_pl[0], 0);
    chk("jnz_nt_next", int'(st_s[0]), 1);

    run_random(0, 40);

    clr();
    fetch_decode(0, 9'h180, 1);
    for (int i = 0; i < 5; i++)
      cyc(0, 1'b0, 1'b1, rb(), rnd9(), rb(), 1'b1, ev(9, F_HL, 9'h180));
    cyc(0, 1'b0, 1'b0, rb(), rnd9(), rb(), 1'b1, ev(9, F_HL, 9'h180));
    cyc(0, 1'b0, 1'b0, rb(), rnd9(), rb(), 1'b1, ev(0, 12'h000, 9'h180));
    chk("halt_len", cnt_hl[0], 6);
    start_run(0);

    clr();
    fetch_decode(0, 9'h1C0, 2);
    for (int i = 0; i < 10; i++)
      cyc(0, 1'b0, rb(), rb(), rnd9(), rb(), 1'b1, ev(15, F_ER, 9'h1C0));
    chk("error_len", cnt_er[0], 10);
    do_reset(0);
    chk("error_cleared", int'(er_s[0]), 0);

    // ALU_CYCLES=4 instance
    do_reset(1);
    start_run(1);
    clr();
    run_instr(1, 9'h10A, 0, 0, 1'b0, 1'b1);
    chk("sub_g_load", cnt_gl[1], 4);
    chk("sub_alu_op", cnt_sub[1], 4);

    run_random(1, 40);

    fetch_decode(1, 9'h08A, 0);
    cyc(1, 1'b0, 1'b1, 1'b0, rnd9(), rb(), 1'b1, ev(5, F_AL, 9'h08A));
    cyc(1, 1'b0, 1'b1, 1'b0, rnd9(), rb(), 1'b1, ev(6, F_GL, 9'h08A));
    cyc(1, 1'b0, 1'b1, 1'b0, rnd9(), rb(), 1'b1, ev(6, F_GL, 9'h08A));
    do_reset(1);
    chk("rst_a2_state", int'(st_s[1]), 0);
    chk("rst_a2_outs", int'(act(1)), 0);
    start_run(1);

    fetch_decode(1, 9'h058, 1);
    cyc(1, 1'b0, 1'b1, 1'b0, rnd9(), rb(), 1'b1, ev(4, F_FR, 9'h058));
    cyc(1, 1'b0, 1'b1, 1'b0, rnd9(), rb(), 1'b1, ev(4, F_FR, 9'h058));
    do_reset(1);
    chk("rst_load_state", int'(st_s[1]), 0);
    chk("rst_load_outs", int'(act(1)), 0);
    start_run(1);
    run_instr(1, 9'h0D1, 1, 0, 1'b0, 1'b0);

    @(posedge clk); #1;
    chk("queues_drained", exp_q.size() + exp_q4.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
